clock_gate_controller: RTL

Sequencer that drives the active-low clock-enable of the glitchless core clock buffer from a set of stall requests. Sits in the free-running clock domain next to the clock buffer. It ORs the request sources, deasserts and reasserts the enable with a fixed settling window, and acknowledges to requesters once the gated clock is known stopped. It also records which sources caused each stop and keeps saturating gated-cycle and stop-event counters for host diagnostics.

---
 rtl/clock_gate_controller.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clock_gate_controller.sv
// Sequences the active-low clock-buffer enable from OR-ed stall requests, with settle windows.
// Latency: CE rises one edge after a request, ack follows CE_LATENCY edges later; restart mirrors it.
// Backpressure: none; requests are levels, and a started stop or restart always runs to completion.
module clock_gate_controller #(
    parameter int NUM_REQ     = 4,
    parameter int CE_LATENCY  = 2,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     io_req,
    input  logic                   io_clear,
    output logic                   io_ce_n,
    output logic                   io_gate_ack,
    output logic                   io_busy,
    output logic [NUM_REQ-1:0]     io_cause,
    output logic [COUNT_WIDTH-1:0] io_gated_cycles,
    output logic [15:0]            io_stop_events
);
    localparam int TW = $clog2(CE_LATENCY + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(CE_LATENCY);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    typedef enum logic [1:0] {
        S_RUNNING  = 2'd0,
        S_STOPPING = 2'd1,
        S_STOPPED  = 2'd2,
        S_STARTING = 2'd3
    } state_t;

    state_t                   state_q;
    logic [TW-1:0]            timer_q;
    logic                     ce_n_q;
    logic                     ack_q;
    logic                     busy_q;
    logic [NUM_REQ-1:0]       cause_q;
    logic [COUNT_WIDTH-1:0]   gated_q, gated_d;
    logic [15:0]              stops_q, stops_d;
    logic                     stop_start;

    assign stop_start = (state_q == S_RUNNING) && (|io_req);

    // The timer is checked against one so the state change lands on the edge it hits zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RUNNING;
            timer_q <= '0;
            ce_n_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            case (state_q)
                S_RUNNING: begin
                    if (|io_req) begin
                        state_q <= S_STOPPING;
                        timer_q <= TIMER_LOAD;
                        ce_n_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        cause_q <= io_req;
                    end
                end
                S_STOPPING: begin
                    if (timer_q <= TIMER_ONE) begin
                        state_q <= S_STOPPED;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                S_STOPPED: begin
                    if (!(|io_req)) begin
                        state_q <= S_STARTING;
                        timer_q <= TIMER_LOAD;
                        ce_n_q  <= 1'b0;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_STARTING: begin
                    if (timer_q <= TIMER_ONE) begin
                        state_q <= S_RUNNING;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: state_q <= S_RUNNING;
            endcase
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_comb begin
        gated_d = gated_q;
        stops_d = stops_q;
        if (io_clear) begin
            gated_d = '0;
            stops_d = '0;
        end else begin
            if (ce_n_q && (gated_q != {COUNT_WIDTH{1'b1}}))
                gated_d = gated_q + COUNT_WIDTH'(1);
            if (stop_start && (stops_q != 16'hFFFF))
                stops_d = stops_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gated_q <= '0;
            stops_q <= '0;
        end else begin
            gated_q <= gated_d;
            stops_q <= stops_d;
        end
    end

    assign io_ce_n         = ce_n_q;
    assign io_gate_ack     = ack_q;
    assign io_busy         = busy_q;
    assign io_cause        = cause_q;
    assign io_gated_cycles = gated_q;
    assign io_stop_events  = stops_q;
endmodule
